// File: rtl/debug_trace_tx.sv
// Debug trace transmitter: snapshots the CPU debug structure on retire or manual
// request and streams it as a fixed 23-byte framed packet over a valid/ready byte link.
package debug_trace_pkg;
  typedef enum logic [2:0] {
    INIT       = 3'd0,
    FETCH      = 3'd1,
    DECODE     = 3'd2,
    EXECUTE    = 3'd3,
    MEMORY     = 3'd4,
    WRITE_BACK = 3'd5
  } exec_state_t;

  typedef struct packed {
    exec_state_t      exec_state;
    logic [2:0]       macro_op;
    logic [3:0]       alu_func;
    logic [4:0]       dst_reg;
    logic [15:0]      alu_out;
    logic [7:0][15:0] reg_file;
  } debug_signals_t;
endpackage

module debug_trace_tx
  import debug_trace_pkg::*;
#(
  parameter logic [7:0] SYNC_BYTE = 8'hA5,
  parameter int         FRAME_LEN = 23
) (
  input  logic           clk,
  input  logic           rst,
  input  debug_signals_t debug_in,
  input  logic           trace_en,
  input  logic           snap_req,
  output logic [7:0]     tx_data,
  output logic           tx_valid,
  input  logic           tx_ready,
  output logic           busy,
  output logic [7:0]     seq,
  output logic [7:0]     drop_cnt
);

  typedef enum logic {IDLE, SEND} tx_state_t;

  localparam logic [4:0] LAST_IDX = 5'(FRAME_LEN - 1);

  tx_state_t        state;
  tx_state_t        state_nxt;
  logic [4:0]       idx;
  exec_state_t      prev_state;

  logic [2:0]       snap_macro;
  logic [3:0]       snap_func;
  logic [4:0]       snap_dst;
  logic [15:0]      snap_alu;
  logic [7:0][15:0] snap_regs;

  logic             retire;
  logic             trig;
  logic             hs;
  logic             last_hs;
  logic             capture;
  logic [7:0]       csum;
  logic [7:0]       frame_byte;
  logic [2:0]       reg_sel;

  always_comb begin
    retire  = trace_en && (debug_in.exec_state == WRITE_BACK) && (prev_state != WRITE_BACK);
    trig    = retire || snap_req;
    hs      = (state == SEND) && tx_ready;
    last_hs = hs && (idx == LAST_IDX);
    capture = trig && ((state == IDLE) || last_hs);
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (capture) state_nxt = SEND;
      SEND:    if (last_hs && !capture) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Control state: FSM, byte index, counters and retire edge detector
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      idx        <= 5'd0;
      seq        <= 8'd0;
      drop_cnt   <= 8'd0;
      prev_state <= INIT;
    end else begin
      state      <= state_nxt;
      prev_state <= debug_in.exec_state;
      if (capture) begin
        seq <= seq + 8'd1;
        idx <= 5'd0;
      end else if (hs) begin
        idx <= idx + 5'd1;
      end
      if (trig && (state == SEND) && !last_hs && (drop_cnt != 8'hFF))
        drop_cnt <= drop_cnt + 8'd1;
    end
  end

  // Snapshot capture: data only, never reset
  always_ff @(posedge clk) begin
    if (capture) begin
      snap_macro <= debug_in.macro_op;
      snap_func  <= debug_in.alu_func;
      snap_dst   <= debug_in.dst_reg;
      snap_alu   <= debug_in.alu_out;
      snap_regs  <= debug_in.reg_file;
    end
  end

  always_comb begin
    csum = seq ^ {snap_macro, 1'b0, snap_func} ^ {3'b000, snap_dst}
         ^ snap_alu[15:8] ^ snap_alu[7:0];
    for (int i = 0; i < 8; i++)
      csum = csum ^ snap_regs[i][15:8] ^ snap_regs[i][7:0];
  end

  // Register bytes start at index 6: even index carries the high half
  always_comb begin
    reg_sel = 3'((idx - 5'd6) >> 1);
    case (idx)
      5'd0:    frame_byte = SYNC_BYTE;
      5'd1:    frame_byte = seq;
      5'd2:    frame_byte = {snap_macro, 1'b0, snap_func};
      5'd3:    frame_byte = {3'b000, snap_dst};
      5'd4:    frame_byte = snap_alu[15:8];
      5'd5:    frame_byte = snap_alu[7:0];
      LAST_IDX: frame_byte = csum;
      default: begin
        if (idx < LAST_IDX)
          frame_byte = idx[0] ? snap_regs[reg_sel][7:0] : snap_regs[reg_sel][15:8];
        else
          frame_byte = 8'h00;
      end
    endcase
  end

  assign tx_valid = (state == SEND);
  assign busy     = tx_valid;
  assign tx_data  = tx_valid ? frame_byte : 8'h00;

endmodule

// File: tb/tb_debug_trace_tx.sv
// Directed bench for debug_trace_tx: frame contents, stalls, drops, back-to-back and reset.
module tb_debug_trace_tx;
  import debug_trace_pkg::*;

  logic           clk = 1'b0;
  logic           rst;
  debug_signals_t dbg;
  logic           trace_en;
  logic           snap_req;
  logic [7:0]     tx_data;
  logic           tx_valid;
  logic           tx_ready;
  logic           busy;
  logic [7:0]     seq;
  logic [7:0]     drop_cnt;

  int         n_checks = 0;
  int         n_fail   = 0;
  logic [7:0] rx  [0:22];
  logic [7:0] exp_b [0:22];
  int         rx_n;
  int         stable_err;

  debug_trace_tx #(.SYNC_BYTE(8'hA5), .FRAME_LEN(23)) dut (
    .clk(clk), .rst(rst), .debug_in(dbg), .trace_en(trace_en), .snap_req(snap_req),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready), .busy(busy),
    .seq(seq), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_dbg(input logic [2:0] m, input logic [3:0] f, input logic [4:0] dr,
                         input logic [15:0] a, input logic [15:0] rbase, input logic [15:0] rstep);
    dbg.macro_op = m;
    dbg.alu_func = f;
    dbg.dst_reg  = dr;
    dbg.alu_out  = a;
    for (int i = 0; i < 8; i++) dbg.reg_file[i] = rbase + rstep * 16'(i);
  endtask

  task automatic build_exp(input logic [7:0] s, input debug_signals_t d);
    logic [7:0] x;
    exp_b[0] = 8'hA5;
    exp_b[1] = s;
    exp_b[2] = {d.macro_op, 1'b0, d.alu_func};
    exp_b[3] = {3'b000, d.dst_reg};
    exp_b[4] = d.alu_out[15:8];
    exp_b[5] = d.alu_out[7:0];
    for (int r = 0; r < 8; r++) begin
      exp_b[6 + 2*r] = d.reg_file[r][15:8];
      exp_b[7 + 2*r] = d.reg_file[r][7:0];
    end
    x = 8'h00;
    for (int k = 1; k <= 21; k++) x = x ^ exp_b[k];
    exp_b[22] = x;
  endtask

  task automatic collect(input int pct, input int nbytes, input int budget);
    logic       prev_stall;
    logic [7:0] prev_data;
    rx_n = 0; stable_err = 0; prev_stall = 1'b0; prev_data = 8'h00;
    for (int c = 0; c < budget && rx_n < nbytes; c++) begin
      tx_ready = (pct >= 100) ? 1'b1 : ($urandom_range(0, 99) < pct);
      if (prev_stall && (!tx_valid || tx_data !== prev_data)) stable_err++;
      if (tx_valid && tx_ready) begin
        rx[rx_n] = tx_data;
        rx_n++;
      end
      prev_stall = tx_valid && !tx_ready;
      prev_data  = tx_data;
      tick();
    end
    tx_ready = 1'b0;
  endtask

  task automatic do_reset();
    dbg.exec_state = FETCH;
    rst = 1'b1; tick(); rst = 1'b0;
  endtask

  task automatic pulse_snap();
    snap_req = 1'b1; tick(); snap_req = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++; if (tx_valid !== 1'b0) begin n_fail++; $display("FAIL reset_tx_valid: got %0h want 0", tx_valid); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %0h want 0", busy); end
    n_checks++; if (tx_data !== 8'h00) begin n_fail++; $display("FAIL reset_tx_data: got %0h want 00", tx_data); end
    n_checks++; if (seq !== 8'h00) begin n_fail++; $display("FAIL reset_seq: got %0h want 00", seq); end
    n_checks++; if (drop_cnt !== 8'h00) begin n_fail++; $display("FAIL reset_drop_cnt: got %0h want 00", drop_cnt); end
  endtask

  task automatic test_basic_frame();
    logic [7:0] hand [0:22];
    hand[0] = 8'hA5; hand[1] = 8'h01; hand[2] = 8'hAA; hand[3] = 8'h03;
    hand[4] = 8'hBE; hand[5] = 8'hEF; hand[22] = 8'hF9;
    for (int r = 0; r < 8; r++) begin
      hand[6 + 2*r] = 8'h11 * 8'(r + 1);
      hand[7 + 2*r] = 8'h11 * 8'(r + 1);
    end
    set_dbg(3'd5, 4'hA, 5'd3, 16'hBEEF, 16'h1111, 16'h1111);
    dbg.exec_state = FETCH; tick();
    dbg.exec_state = DECODE; tick();
    dbg.exec_state = WRITE_BACK;
    n_checks++; if (tx_valid !== 1'b0) begin n_fail++; $display("FAIL basic_pre_valid: got %0h want 0", tx_valid); end
    tick();
    n_checks++; if (tx_valid !== 1'b1) begin n_fail++; $display("FAIL basic_latency_valid: got %0h want 1", tx_valid); end
    n_checks++; if (tx_data !== 8'hA5) begin n_fail++; $display("FAIL basic_first_byte: got %0h want a5", tx_data); end
    collect(100, 23, 100);
    dbg.exec_state = FETCH;
    n_checks++; if (rx_n !== 23) begin n_fail++; $display("FAIL basic_handshakes: got %0d want 23", rx_n); end
    for (int i = 0; i < 23; i++) begin
      n_checks++; if (rx[i] !== hand[i]) begin n_fail++; $display("FAIL basic_byte%0d: got %0h want %0h", i, rx[i], hand[i]); end
    end
    n_checks++; if (tx_valid !== 1'b0) begin n_fail++; $display("FAIL basic_post_valid: got %0h want 0", tx_valid); end
  endtask

  task automatic test_hold_wb();
    do_reset();
    set_dbg(3'd2, 4'h3, 5'd17, 16'h1234, 16'h0102, 16'h0304);
    dbg.exec_state = DECODE; tick();
    dbg.exec_state = WRITE_BACK; tick();
    collect(100, 23, 100);
    for (int c = 0; c < 5; c++) tick();
    n_checks++; if (tx_valid !== 1'b0) begin n_fail++; $display("FAIL hold_wb_idle: got %0h want 0", tx_valid); end
    n_checks++; if (seq !== 8'h01) begin n_fail++; $display("FAIL hold_wb_seq: got %0h want 01", seq); end
    n_checks++; if (rx[1] !== 8'h01) begin n_fail++; $display("FAIL hold_wb_frame_seq: got %0h want 01", rx[1]); end
    n_checks++; if (drop_cnt !== 8'h00) begin n_fail++; $display("FAIL hold_wb_drops: got %0h want 00", drop_cnt); end
    dbg.exec_state = FETCH; tick();
  endtask

  task automatic test_random_stall();
    do_reset();
    set_dbg(3'd7, 4'hF, 5'd31, 16'h8001, 16'hF00D, 16'h1357);
    build_exp(8'h01, dbg);
    pulse_snap();
    collect(30, 23, 2000);
    n_checks++; if (rx_n !== 23) begin n_fail++; $display("FAIL stall_handshakes: got %0d want 23", rx_n); end
    n_checks++; if (stable_err !== 0) begin n_fail++; $display("FAIL stall_data_stable: got %0d changes want 0", stable_err); end
    for (int i = 0; i < 23; i++) begin
      n_checks++; if (rx[i] !== exp_b[i]) begin n_fail++; $display("FAIL stall_byte%0d: got %0h want %0h", i, rx[i], exp_b[i]); end
    end
  endtask

  task automatic test_stall_drops();
    do_reset();
    set_dbg(3'd1, 4'h6, 5'd9, 16'h5AA5, 16'h2000, 16'h0111);
    build_exp(8'h01, dbg);
    pulse_snap();
    tx_ready = 1'b0;
    for (int c = 0; c < 100; c++) begin
      if (c == 10 || c == 40 || c == 70) dbg.exec_state = DECODE;
      if (c == 11 || c == 41 || c == 71) dbg.exec_state = WRITE_BACK;
      if (c == 20) set_dbg(3'd6, 4'h1, 5'd2, 16'hDEAD, 16'hCAFE, 16'h0001);
      tick();
    end
    dbg.exec_state = FETCH;
    n_checks++; if (drop_cnt !== 8'd3) begin n_fail++; $display("FAIL drops_count: got %0d want 3", drop_cnt); end
    n_checks++; if (seq !== 8'h01) begin n_fail++; $display("FAIL drops_seq: got %0h want 01", seq); end
    n_checks++; if (tx_data !== 8'hA5) begin n_fail++; $display("FAIL drops_held_byte: got %0h want a5", tx_data); end
    collect(100, 23, 100);
    for (int i = 0; i < 23; i++) begin
      n_checks++; if (rx[i] !== exp_b[i]) begin n_fail++; $display("FAIL drops_byte%0d: got %0h want %0h", i, rx[i], exp_b[i]); end
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    set_dbg(3'd4, 4'h9, 5'd12, 16'h0F0F, 16'hA0A0, 16'h0A0A);
    build_exp(8'h01, dbg);
    pulse_snap();
    collect(100, 22, 100);
    n_checks++; if (tx_data !== exp_b[22]) begin n_fail++; $display("FAIL b2b_csum: got %0h want %0h", tx_data, exp_b[22]); end
    snap_req = 1'b1; tx_ready = 1'b1;
    tick();
    snap_req = 1'b0; tx_ready = 1'b0;
    n_checks++; if (tx_valid !== 1'b1) begin n_fail++; $display("FAIL b2b_no_gap: got %0h want 1", tx_valid); end
    n_checks++; if (tx_data !== 8'hA5) begin n_fail++; $display("FAIL b2b_sync: got %0h want a5", tx_data); end
    n_checks++; if (seq !== 8'h02) begin n_fail++; $display("FAIL b2b_seq: got %0h want 02", seq); end
    build_exp(8'h02, dbg);
    collect(100, 23, 100);
    for (int i = 0; i < 23; i++) begin
      n_checks++; if (rx[i] !== exp_b[i]) begin n_fail++; $display("FAIL b2b_byte%0d: got %0h want %0h", i, rx[i], exp_b[i]); end
    end
  endtask

  task automatic test_reset_midframe();
    do_reset();
    set_dbg(3'd3, 4'h2, 5'd5, 16'h7777, 16'h1000, 16'h0100);
    pulse_snap();
    collect(100, 10, 100);
    n_checks++; if (tx_valid !== 1'b1) begin n_fail++; $display("FAIL midrst_active: got %0h want 1", tx_valid); end
    rst = 1'b1; tick(); rst = 1'b0;
    n_checks++; if (tx_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_valid: got %0h want 0", tx_valid); end
    n_checks++; if (seq !== 8'h00) begin n_fail++; $display("FAIL midrst_seq: got %0h want 00", seq); end
    n_checks++; if (tx_data !== 8'h00) begin n_fail++; $display("FAIL midrst_data: got %0h want 00", tx_data); end
    build_exp(8'h01, dbg);
    pulse_snap();
    collect(100, 23, 100);
    for (int i = 0; i < 23; i++) begin
      n_checks++; if (rx[i] !== exp_b[i]) begin n_fail++; $display("FAIL midrst_byte%0d: got %0h want %0h", i, rx[i], exp_b[i]); end
    end
  endtask

  task automatic test_trace_en();
    do_reset();
    trace_en = 1'b0;
    dbg.exec_state = DECODE; tick();
    dbg.exec_state = WRITE_BACK; tick(); tick();
    n_checks++; if (tx_valid !== 1'b0) begin n_fail++; $display("FAIL trace_off_valid: got %0h want 0", tx_valid); end
    n_checks++; if (seq !== 8'h00) begin n_fail++; $display("FAIL trace_off_seq: got %0h want 00", seq); end
    pulse_snap();
    n_checks++; if (tx_valid !== 1'b1) begin n_fail++; $display("FAIL trace_off_snap: got %0h want 1", tx_valid); end
    collect(100, 23, 100);
    trace_en = 1'b1;
    dbg.exec_state = DECODE; tick();
    dbg.exec_state = WRITE_BACK; snap_req = 1'b1; tick(); snap_req = 1'b0;
    n_checks++; if (seq !== 8'h02) begin n_fail++; $display("FAIL dual_trig_seq: got %0h want 02", seq); end
    n_checks++; if (drop_cnt !== 8'h00) begin n_fail++; $display("FAIL dual_trig_drops: got %0h want 00", drop_cnt); end
    collect(100, 23, 100);
    dbg.exec_state = FETCH; tick();
  endtask

  task automatic test_drop_saturate();
    do_reset();
    pulse_snap();
    tx_ready = 1'b0;
    snap_req = 1'b1;
    for (int c = 0; c < 300; c++) tick();
    snap_req = 1'b0;
    n_checks++; if (drop_cnt !== 8'hFF) begin n_fail++; $display("FAIL drop_saturate: got %0h want ff", drop_cnt); end
    n_checks++; if (seq !== 8'h01) begin n_fail++; $display("FAIL drop_sat_seq: got %0h want 01", seq); end
    n_checks++; if (tx_data !== 8'hA5) begin n_fail++; $display("FAIL drop_sat_byte: got %0h want a5", tx_data); end
  endtask

  initial begin
    rst = 1'b1; trace_en = 1'b1; snap_req = 1'b0; tx_ready = 1'b0;
    dbg = '0;
    dbg.exec_state = INIT;
    tick(); tick();
    rst = 1'b0;
    test_reset();
    test_basic_frame();
    test_hold_wb();
    test_random_stall();
    test_stall_drops();
    test_back_to_back();
    test_reset_midframe();
    test_trace_en();
    test_drop_saturate();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
